aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Parametrised AES key-schedule engine supporting AES-128, AES-192 and AES-256. The mode is selected per operation. On a start pulse it captures the cipher key, generates one 32-bit schedule word per clock, and streams the Nr+1 round keys as 128-bit words with a valid strobe and round index. It is the multi-mode successor to the single-mode round-key generator and feeds the cipher/inverse-cipher round datapath.

## Interface
- KEY_W, 256: widest key the instance supports; legal values 128, 192, 256. Modes needing a wider key are rejected.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only while busy=0
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=illegal; sampled with start
- key  in  KEY_W  cipher key, bit 0 = MSB, left-aligned; AES-128 uses key[0:127], AES-192 uses key[0:191]; sampled with start
- busy  out  1  high from accepted start until the final round key is emitted
- rk_valid  out  1  one-cycle strobe, round key present on rk
- rk_idx  out  4  round index of rk, 0..Nr
- rk  out  128  round key, w[4k] in bits 0:31 through w[4k+3] in bits 96:127
- done  out  1  one-cycle pulse coincident with the last rk_valid
- err  out  1  one-cycle pulse on a rejected start

## Operation
- Reset: busy=0, rk_valid=0, rk_idx=0, rk=0, done=0, err=0; all internal state is cleared. An asserted rst_n mid-operation aborts the schedule; no further rk_valid occurs.
- Mode parameters: Nk=4/6/8 and Nr=10/12/14 for key_len 0/1/2. Total words W=4(Nr+1), giving 44/52/60.
- States:
  - IDLE: on start, either accept or reject. Reject when key_len=3, or when 32·Nk > KEY_W; a rejection pulses err for one cycle and stays in IDLE. An accepted start latches the key and Nk, sets word counter i=0, sets busy, and moves to GEN.
  - GEN: one word w[i] per cycle. Return to IDLE after w[W-1].
- Word rule:
  - i < Nk: w[i] = key word i.
  - else: w[i] = w[i-Nk] XOR t, where t = w[i-1] with these transforms:
    - i mod Nk = 0: t = SubWord(RotWord(w[i-1])) XOR {Rcon[i/Nk],00,00,00}.
    - Nk=8 and i mod 8 = 4: t = SubWord(w[i-1]).
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (GF(2^8) doubling).
- SubWord applies the FIPS-197 S-box to each byte. RotWord is a left rotate by one byte.
- History storage: an 8-word shift window of the most recent words. w[i-Nk] is selected by the latched Nk.
- Output: when i mod 4 = 3, the four newest words load rk, and rk_idx=i/4, with rk_valid the following cycle.
- No backpressure: the consumer must accept every strobe.
- start while busy=1 is ignored; no err is raised.
- key and key_len may change freely after the accepting edge.

## Timing
- Accepting edge = E0. w[i] is registered at edge E(i+1). Round key k is valid in the cycle after edge E(4k+4), i.e. exactly every 4th cycle; the cadence is uniform across modes.
- Last round key is valid in the cycle after E(W): cycle 44/52/60 after E0. done is coincident with it.
- busy rises after E0 and falls at the edge ending the done cycle.
- A new start is accepted in the cycle done is high. Back-to-back operations have no idle gap.
- err is high in the cycle after the rejecting edge.
- S-box lookup and XOR path are combinational within one cycle. There is no multicycle path.

## Test plan
- AES-128, key 0: rk_idx 10 = b4ef5bcb3e92e21123e951cf6f8f188e. done is in cycle 44 after start, and exactly 11 strobes occur, spaced 4 cycles apart.
- AES-128 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - rk_idx 0 = key.
  - rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: rk_idx 12 = e98ba06f448c773c8ecc720401002202. done is in cycle 52, with 13 strobes.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk_idx 14 = fe4890d1e6188d0b046df344706c631e. done is in cycle 60, with 15 strobes.
  - This checks the i mod 8 = 4 SubWord path.
- Rejection:
  - key_len=3 gives err for one cycle, with busy and rk_valid staying 0.
  - With KEY_W=128, key_len=2 also gives err.
  - start during busy causes no err and no disturbance of the stream.
- Reset and back-to-back:
  - rst_n low for 1 cycle at round 5 makes all outputs 0 immediately and keeps them 0 afterwards.
  - After release, a new AES-128 run produces correct keys.
  - start asserted in the done cycle begins the next schedule with rk_idx 0 valid 4 cycles later.

Source files
------------

// File: rtl/aes_key_schedule.sv
// Multi-mode AES key-schedule engine (AES-128/192/256). It generates one schedule word per
// clock and emits a 128-bit round key every fourth cycle.
module aes_key_schedule #(
  parameter int KEY_W = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic [0:KEY_W-1] key,
  output logic             busy,
  output logic             rk_valid,
  output logic [3:0]       rk_idx,
  output logic [0:127]     rk,
  output logic             done,
  output logic             err
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, GEN} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t       state, state_nxt;
  logic [0:255] key_q, key_pad;
  logic [3:0]   nk, req_nk;
  logic [5:0]   last_i, req_last;
  logic [5:0]   i;
  logic [2:0]   j;
  logic [7:0]   rcon;
  logic [31:0]  hist [8];
  logic [31:0]  prev, back, kw, t, w_new;
  logic         reject, accept, rej;

  always_comb begin
    key_pad = '0;
    key_pad[0:KEY_W-1] = key;
    req_nk   = 4'd0;
    req_last = 6'd0;
    case (key_len)
      2'd0: begin req_nk = 4'd4; req_last = 6'd43; end
      2'd1: begin req_nk = 4'd6; req_last = 6'd51; end
      2'd2: begin req_nk = 4'd8; req_last = 6'd59; end
      default: begin req_nk = 4'd0; req_last = 6'd0; end
    endcase
    reject = (key_len == 2'd3) || ((32 * int'(req_nk)) > KEY_W);
    accept = start && (state == IDLE) && !reject;
    rej    = start && (state == IDLE) && reject;
  end

  // j tracks i mod Nk, so the RotWord/Rcon and the extra AES-256 SubWord need no divider
  always_comb begin
    prev = hist[0];
    back = hist[3'(nk - 4'd1)];
    kw   = key_q[{i[2:0], 5'b00000} +: 32];
    t    = prev;
    if (j == 3'd0)
      t = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h000000};
    else if ((nk == 4'd8) && (j == 3'd4))
      t = sub_word(prev);
    w_new = (i < {2'b00, nk}) ? kw : (back ^ t);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = GEN;
      GEN:     if (i == last_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      rk       <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      key_q    <= '0;
      nk       <= '0;
      last_i   <= '0;
      i        <= '0;
      j        <= '0;
      rcon     <= '0;
      for (int k = 0; k < 8; k++) hist[k] <= '0;
    end else begin
      state    <= state_nxt;
      err      <= rej;
      busy     <= accept || (state == GEN);
      rk_valid <= 1'b0;
      done     <= 1'b0;
      if (accept) begin
        key_q  <= key_pad;
        nk     <= req_nk;
        last_i <= req_last;
        i      <= '0;
        j      <= '0;
        rcon   <= 8'h01;
      end else if (state == GEN) begin
        for (int k = 7; k > 0; k--) hist[k] <= hist[k-1];
        hist[0] <= w_new;
        i <= i + 6'd1;
        j <= (({1'b0, j} + 4'd1) == nk) ? 3'd0 : j + 3'd1;
        if ((i >= {2'b00, nk}) && (j == 3'd0)) rcon <= xtime(rcon);
        // The fourth word of a group completes a round key, registered with the word itself
        if (i[1:0] == 2'b11) begin
          rk       <= {hist[2], hist[1], hist[0], w_new};
          rk_idx   <= i[5:2];
          rk_valid <= 1'b1;
          done     <= (i == last_i);
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: a scoreboard of expected round-key strobes is
// filled at each start and drained by a monitor at every falling edge.
module tb_aes_key_schedule;

  typedef struct {
    int           idx;
    int           cyc;
    bit           chk;
    logic [127:0] val;
    bit           last;
  } exp_t;

  logic         clk, rst_n, start;
  logic [1:0]   key_len;
  logic [0:255] key;
  logic         busy, rk_valid, done, err;
  logic [3:0]   rk_idx;
  logic [0:127] rk;

  logic         start128;
  logic [1:0]   len128;
  logic [0:127] key128;
  logic         busy128, rk_valid128, done128, err128;
  logic [3:0]   rk_idx128;
  logic [0:127] rk128;

  exp_t q[$];
  exp_t mon_e;
  int   ncmp = 0, nfail = 0, cyc = 0, stb = 0, ndone = 0;
  int   c0, c1, snap, n;

  localparam logic [0:255] K0   = 256'h0;
  localparam logic [0:255] FIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule #(.KEY_W(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .rk_valid(rk_valid), .rk_idx(rk_idx), .rk(rk), .done(done), .err(err)
  );

  aes_key_schedule #(.KEY_W(128)) u128 (
    .clk(clk), .rst_n(rst_n), .start(start128), .key_len(len128), .key(key128),
    .busy(busy128), .rk_valid(rk_valid128), .rk_idx(rk_idx128), .rk(rk128), .done(done128),
    .err(err128)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expectation in index, cycle and done
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (done) ndone++;
      if (rk_valid) begin
        stb++;
        ncmp++;
        assert (q.size() > 0) else begin
          nfail++;
          $error("FAIL spurious_strobe: observed rk_idx %0d at cycle %0d, required no strobe", rk_idx, cyc);
        end
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          chk("rk_idx", 128'(rk_idx), 128'(mon_e.idx));
          chk("strobe_cycle", 128'(cyc), 128'(mon_e.cyc));
          chk("done_with_last", 128'(done), 128'(mon_e.last));
          if (mon_e.chk) chk($sformatf("rk[%0d]", mon_e.idx), rk, mon_e.val);
        end
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic launch(input logic [1:0] len, input logic [0:255] k, output int c);
    int nr;
    nr = (len == 2'd0) ? 10 : (len == 2'd1) ? 12 : 14;
    start = 1'b1; key_len = len; key = k;
    c = cyc + 1;
    for (int r = 0; r <= nr; r++)
      q.push_back('{idx: r, cyc: c + 4*r + 4, chk: 1'b0, val: 128'h0, last: (r == nr)});
    @(negedge clk);
    start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_len = 2'($urandom_range(0, 3));
  endtask

  task automatic set_exp(input int c, input int idx, input logic [127:0] v);
    exp_t e;
    for (int m = 0; m < q.size(); m++) begin
      if (q[m].cyc == c + 4*idx + 4) begin
        e = q[m]; e.chk = 1'b1; e.val = v; q[m] = e;
      end
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int w = 0;
    while (q.size() > 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    ncmp++;
    assert (q.size() == 0) else begin
      nfail++;
      $error("FAIL %s_timeout: observed %0d strobes pending, required 0", tag, q.size());
    end
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; key_len = 2'd0; key = '0;
    start128 = 1'b0; len128 = 2'd0; key128 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_rk_valid", 128'(rk_valid), 128'(0));
    chk("reset_rk_idx", 128'(rk_idx), 128'(0));
    chk("reset_rk", rk, 128'h0);
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_err", 128'(err), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // AES-128 all-zero key, including cadence and busy fall after done
    stb = 0; ndone = 0;
    launch(2'd0, K0, c0);
    set_exp(c0, 0, 128'h0);
    set_exp(c0, 1, 128'h62636363626363636263636362636363);
    set_exp(c0, 2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    set_exp(c0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    wait_until(c0 + 1);
    chk("busy_after_accept", 128'(busy), 128'(1));
    wait_until(c0 + 44);
    chk("done_cycle44", 128'(done), 128'(1));
    chk("busy_in_done", 128'(busy), 128'(1));
    wait_until(c0 + 45);
    chk("busy_after_done", 128'(busy), 128'(0));
    chk("done_one_cycle", 128'(done), 128'(0));
    drain(10, "aes128_zero");
    chk("aes128_strobes", 128'(stb), 128'(11));
    chk("aes128_done_count", 128'(ndone), 128'(1));

    // AES-128 FIPS key with starts issued while busy
    launch(2'd0, FIPS, c0);
    set_exp(c0, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    set_exp(c0, 1, 128'ha0fafe1788542cb123a339392a6c7605);
    set_exp(c0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_until(c0 + 9);
    start = 1'b1; key_len = 2'd3; key = K256;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_no_err", 128'(err), 128'(0));
    wait_until(c0 + 17);
    start = 1'b1; key_len = 2'd2; key = K256;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_err2", 128'(err), 128'(0));
    chk("busy_start_busy", 128'(busy), 128'(1));
    drain(60, "aes128_fips");

    // AES-192
    stb = 0; ndone = 0;
    launch(2'd1, K192, c0);
    set_exp(c0, 0, 128'h8e73b0f7da0e6452c810f32b809079e5);
    set_exp(c0, 12, 128'he98ba06f448c773c8ecc720401002202);
    drain(70, "aes192");
    chk("aes192_strobes", 128'(stb), 128'(13));
    chk("aes192_done_count", 128'(ndone), 128'(1));

    // AES-256
    stb = 0; ndone = 0;
    launch(2'd2, K256, c0);
    set_exp(c0, 0, 128'h603deb1015ca71be2b73aef0857d7781);
    set_exp(c0, 1, 128'h1f352c073b6108d72d9810a30914dff4);
    set_exp(c0, 2, 128'h9ba354118e6925afa51a8b5f2067fcde);
    set_exp(c0, 14, 128'hfe4890d1e6188d0b046df344706c631e);
    drain(80, "aes256");
    chk("aes256_strobes", 128'(stb), 128'(15));
    chk("aes256_done_count", 128'(ndone), 128'(1));

    // Illegal mode
    @(negedge clk);
    start = 1'b1; key_len = 2'd3; key = K256;
    @(negedge clk);
    start = 1'b0;
    chk("reject3_err", 128'(err), 128'(1));
    chk("reject3_busy", 128'(busy), 128'(0));
    chk("reject3_rk_valid", 128'(rk_valid), 128'(0));
    @(negedge clk);
    chk("reject3_err_pulse", 128'(err), 128'(0));

    // 128-bit instance: AES-256 rejected, AES-128 accepted
    start128 = 1'b1; len128 = 2'd2; key128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    @(negedge clk);
    start128 = 1'b0;
    chk("k128_reject_err", 128'(err128), 128'(1));
    chk("k128_reject_busy", 128'(busy128), 128'(0));
    start128 = 1'b1; len128 = 2'd0;
    @(negedge clk);
    start128 = 1'b0;
    chk("k128_accept_busy", 128'(busy128), 128'(1));
    chk("k128_accept_err", 128'(err128), 128'(0));
    n = 0;
    while (!done128 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("k128_done", 128'(done128), 128'(1));
    chk("k128_rk10", rk128, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("k128_idx10", 128'(rk_idx128), 128'(10));
    @(negedge clk);

    // Asynchronous reset two cycles after round 5
    launch(2'd0, FIPS, c0);
    set_exp(c0, 5, 128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    wait_until(c0 + 26);
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 128'(busy), 128'(0));
    chk("midreset_rk_valid", 128'(rk_valid), 128'(0));
    chk("midreset_rk_idx", 128'(rk_idx), 128'(0));
    chk("midreset_rk", rk, 128'h0);
    chk("midreset_done", 128'(done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    snap = stb;
    repeat (60) @(negedge clk);
    chk("post_reset_no_strobe", 128'(stb), 128'(snap));
    chk("post_reset_busy", 128'(busy), 128'(0));
    chk("post_reset_rk", rk, 128'h0);

    launch(2'd0, FIPS, c0);
    set_exp(c0, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    set_exp(c0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    drain(60, "after_reset");

    // Back-to-back: AES-256 started in the AES-128 done cycle
    stb = 0; ndone = 0;
    launch(2'd0, K0, c0);
    set_exp(c0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    wait_until(c0 + 44);
    chk("b2b_done", 128'(done), 128'(1));
    launch(2'd2, K256, c1);
    set_exp(c1, 0, 128'h603deb1015ca71be2b73aef0857d7781);
    set_exp(c1, 14, 128'hfe4890d1e6188d0b046df344706c631e);
    chk("b2b_busy_held", 128'(busy), 128'(1));
    drain(80, "back_to_back");
    chk("b2b_strobes", 128'(stb), 128'(26));
    chk("b2b_done_count", 128'(ndone), 128'(2));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
